// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//
// Shared types and helpers for the ALU result stage.
//   - ALU_Sel encodings for the three operations the ALU implements.
//   - alu_res_t: one captured ALU result (data, flags, sel, destination).
//   - sel_legal(): true for the encodings writeback may commit.
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_RD_W   = 5;
    localparam int ALU_SEL_W  = 4;

    localparam logic [ALU_SEL_W-1:0] ALU_SEL_AND = 4'b0000;
    localparam logic [ALU_SEL_W-1:0] ALU_SEL_OR  = 4'b0001;
    localparam logic [ALU_SEL_W-1:0] ALU_SEL_ADD = 4'b0010;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic                  z;
        logic                  cout;
        logic [ALU_SEL_W-1:0]  sel;
        logic [ALU_RD_W-1:0]   rd;
    } alu_res_t;

    function automatic logic sel_legal(input logic [ALU_SEL_W-1:0] sel);
        return (sel == ALU_SEL_AND) || (sel == ALU_SEL_OR) || (sel == ALU_SEL_ADD);
    endfunction

endpackage

// File: rtl/alu_res_skid.sv
// ----------------------------------------------------------------------------
// alu_res_skid
//
// One storage entry of the result stage: a valid bit plus an alu_res_t.
// The parent decides when to load or clear; this block only holds state.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (valid and data go to 0)
//   load_i   in   capture d_i and set valid
//   clear_i  in   drop the entry (wins over load_i)
//   d_i      in   entry to capture
//   valid_o  out  entry holds a result
//   q_o      out  held result
// ----------------------------------------------------------------------------
module alu_res_skid
    import alu_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load_i,
    input  logic     clear_i,
    input  alu_res_t d_i,
    output logic     valid_o,
    output alu_res_t q_o
);

    logic     valid_q;
    alu_res_t data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            // Data is left as is; it is don't-care once valid drops.
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= d_i;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule

// File: rtl/alu_result_stage.sv
// ----------------------------------------------------------------------------
// alu_result_stage
//
// Registered stage behind the 32-bit ALU. Captures ALU_Out, z, coutfin, the
// producing ALU_Sel and the destination register, and hands them to
// writeback. A main register plus one skid entry let the ALU side see a
// registered in_ready, so writeback back-pressure never reaches the ALU
// combinationally.
//
// Handshake (both sides): a beat transfers on a rising edge where valid and
// ready are both high. A producer holding valid keeps its payload stable
// until the transfer; ready never depends combinationally on valid.
//
// Optional feature: define ALU_RES_PERF_EN to add saturating perf counters
// (perf_acc, perf_stall) and the CNT_W parameter.
//
// Ports:
//   clk, rst_n                clock / async active-low reset
//   flush                     synchronous kill of all buffered results
//   in_valid / in_ready       ALU-side handshake (in_ready = !skid valid)
//   in_result/z/cout/sel/rd   ALU result, flags, ALU_Sel, destination
//   out_valid / out_ready     writeback-side handshake
//   out_result/z/cout/rd      registered result fields
//   out_wb_en                 out_valid && legal sel && out_rd != 0
//   perf_acc, perf_stall      accepted beats / stall cycles (ALU_RES_PERF_EN)
// ----------------------------------------------------------------------------
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int RD_W   = ALU_RD_W,
    parameter int SEL_W  = ALU_SEL_W
`ifdef ALU_RES_PERF_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_z,
    input  logic              in_cout,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_z,
    output logic              out_cout,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wb_en
`ifdef ALU_RES_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_acc,
    output logic [CNT_W-1:0]  perf_stall
`endif
);

    alu_res_t in_res;
    alu_res_t main_d, main_q;
    alu_res_t skid_q;
    logic     main_valid, skid_valid;
    logic     main_load, main_clear;
    logic     skid_load, skid_clear;
    logic     accept, drain;

    assign in_res = '{result: in_result, z: in_z, cout: in_cout, sel: in_sel, rd: in_rd};

    // skid_valid is a flop output, so in_ready is registered.
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign drain    = main_valid && out_ready;

    // The skid entry is older than anything on the input, so it refills
    // main first to keep FIFO order.
    assign main_d = skid_valid ? skid_q : in_res;

    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            // skid_valid implies main_valid, so "drain || !main_valid"
            // reduces to drain on this branch.
            if (skid_valid && drain) begin
                main_load  = 1'b1;
                skid_clear = 1'b1;
            end else if (accept && (drain || !main_valid)) begin
                main_load = 1'b1;
            end else if (drain) begin
                main_clear = 1'b1;
            end
            // accept implies skid empty, so this never collides with skid_clear.
            if (accept && main_valid && !out_ready) begin
                skid_load = 1'b1;
            end
        end
    end

    alu_res_skid u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (main_load),
        .clear_i (main_clear),
        .d_i     (main_d),
        .valid_o (main_valid),
        .q_o     (main_q)
    );

    alu_res_skid u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .d_i     (in_res),
        .valid_o (skid_valid),
        .q_o     (skid_q)
    );

    assign out_valid  = main_valid;
    assign out_result = main_q.result;
    assign out_z      = main_q.z;
    assign out_cout   = main_q.cout;
    assign out_rd     = main_q.rd;
    // Illegal sel results still flow through but must not be committed;
    // rd 0 is the hardwired zero register.
    assign out_wb_en  = main_valid && sel_legal(main_q.sel) && (main_q.rd != '0);

`ifdef ALU_RES_PERF_EN
    logic [CNT_W-1:0] perf_acc_q, perf_acc_d;
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_acc_d   = perf_acc_q;
        perf_stall_d = perf_stall_q;
        if (accept && !flush && (perf_acc_q != '1)) begin
            perf_acc_d = perf_acc_q + CNT_W'(1);
        end
        if (main_valid && !out_ready && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + CNT_W'(1);
        end
    end

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_acc_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_acc_q   <= perf_acc_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_acc   = perf_acc_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int W = 40; // {result, z, cout, rd, wb_en}

    // ------------------------------------------------------------------
    // clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_z;
    logic        in_cout;
    logic [3:0]  in_sel;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_z;
    logic        out_cout;
    logic [4:0]  out_rd;
    logic        out_wb_en;
`ifdef ALU_RES_PERF_EN
    logic [15:0] perf_acc;
    logic [15:0] perf_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    alu_result_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_z       (in_z),
        .in_cout    (in_cout),
        .in_sel     (in_sel),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_z      (out_z),
        .out_cout   (out_cout),
        .out_rd     (out_rd),
        .out_wb_en  (out_wb_en)
`ifdef ALU_RES_PERF_EN
        ,
        .perf_acc   (perf_acc),
        .perf_stall (perf_stall)
`endif
    );

    // ------------------------------------------------------------------
    // driver tasks
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] sel, input logic [31:0] res,
                         input logic z, input logic cout, input logic [4:0] rd);
        in_valid  = 1'b1;
        in_sel    = sel;
        in_result = res;
        in_z      = z;
        in_cout   = cout;
        in_rd     = rd;
    endtask

    // ------------------------------------------------------------------
    // scoreboard: push on accept, pop/compare on drain (sampled at negedge)
    // ------------------------------------------------------------------
    logic [W-1:0] sb_exp;
    logic         sb_wb;

    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    sb_exp = exp_q.pop_front();
                    check("sb_beat", 64'({out_result, out_z, out_cout, out_rd, out_wb_en}), 64'(sb_exp));
                end
            end
            if (in_valid && in_ready) begin
                sb_wb = (in_sel <= 4'd2) && (in_rd != 5'd0);
                exp_q.push_back({in_result, in_z, in_cout, in_rd, sb_wb});
            end
        end
    end

    // ------------------------------------------------------------------
    // directed stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_z      = 1'b0;
        in_cout   = 1'b0;
        in_sel    = '0;
        in_rd     = '0;
        out_ready = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_wb_en", 64'(out_wb_en), 64'd0);
        rst_n = 1'b1;
        step();

        // streaming, 1-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(ALU_SEL_ADD, 32'(5 + i), 1'b0, 1'b0, 5'(i + 1));
            step();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_result", 64'(out_result), 64'(5 + i));
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_empty", 64'(out_valid), 64'd0);

        // back-pressure: A in main, B in skid
        out_ready = 1'b0;
        drive(ALU_SEL_OR, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd3);
        step();
        check("bp_a_valid", 64'(out_valid), 64'd1);
        check("bp_a_in_ready", 64'(in_ready), 64'd1);
        drive(ALU_SEL_AND, 32'h0, 1'b1, 1'b0, 5'd4);
        step();
        check("bp_full_in_ready", 64'(in_ready), 64'd0);
        check("bp_hold_result", 64'(out_result), 64'hFFFF_FFFF);
        in_valid = 1'b0;
        step();
        check("bp_hold2_result", 64'(out_result), 64'hFFFF_FFFF);
        check("bp_hold2_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        check("bp_b_valid", 64'(out_valid), 64'd1);
        check("bp_b_result", 64'(out_result), 64'd0);
        check("bp_b_rd", 64'(out_rd), 64'd4);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        step();
        check("bp_drained", 64'(out_valid), 64'd0);

        // flags and wb_en
        drive(ALU_SEL_ADD, 32'h0, 1'b1, 1'b1, 5'd0);
        step();
        check("flag_z", 64'(out_z), 64'd1);
        check("flag_cout", 64'(out_cout), 64'd1);
        check("wb_en_rd0", 64'(out_wb_en), 64'd0);
        drive(ALU_SEL_ADD, 32'h0, 1'b1, 1'b1, 5'd5);
        step();
        check("wb_en_rd5", 64'(out_wb_en), 64'd1);
        drive(ALU_SEL_OR, 32'h1234_5678, 1'b0, 1'b0, 5'd31);
        step();
        check("wb_en_or", 64'(out_wb_en), 64'd1);
        drive(4'b0111, 32'h0, 1'b1, 1'b0, 5'd5);
        step();
        check("wb_en_illegal", 64'(out_wb_en), 64'd0);
        check("illegal_valid", 64'(out_valid), 64'd1);
        check("illegal_z", 64'(out_z), 64'd1);
        in_valid = 1'b0;
        step();

        // flush with both entries full
        out_ready = 1'b0;
        drive(ALU_SEL_ADD, 32'd11, 1'b0, 1'b0, 5'd1);
        step();
        drive(ALU_SEL_ADD, 32'd22, 1'b0, 1'b0, 5'd2);
        step();
        check("fl_full", 64'(in_ready), 64'd0);
        drive(ALU_SEL_ADD, 32'd33, 1'b0, 1'b0, 5'd3);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        check("fl_stay_empty", 64'(out_valid), 64'd0);
        // beat accepted in the flush cycle is discarded
        drive(ALU_SEL_ADD, 32'd44, 1'b0, 1'b0, 5'd4);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_acc_dropped", 64'(out_valid), 64'd0);
        step();
        check("fl_acc_dropped2", 64'(out_valid), 64'd0);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        drive(ALU_SEL_ADD, 32'd55, 1'b0, 1'b0, 5'd6);
        step();
        drive(ALU_SEL_ADD, 32'd66, 1'b0, 1'b0, 5'd7);
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check("rst_mid_result", 64'(out_result), 64'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        check("rst_rel_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        drive(ALU_SEL_ADD, 32'd77, 1'b0, 1'b0, 5'd8);
        step();
        check("rst_rel_valid", 64'(out_valid), 64'd1);
        check("rst_rel_result", 64'(out_result), 64'd77);
        in_valid = 1'b0;
        step();
        check("rst_rel_drained", 64'(out_valid), 64'd0);

`ifdef ALU_RES_PERF_EN
        // perf counters: 4 accepts, 3 stall cycles
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        out_ready = 1'b0;
        drive(ALU_SEL_ADD, 32'd1, 1'b0, 1'b0, 5'd1);
        step();
        drive(ALU_SEL_ADD, 32'd2, 1'b0, 1'b0, 5'd2);
        step();
        in_valid = 1'b0;
        step();
        step();
        out_ready = 1'b1;
        step();
        drive(ALU_SEL_ADD, 32'd3, 1'b0, 1'b0, 5'd3);
        step();
        drive(ALU_SEL_ADD, 32'd4, 1'b0, 1'b0, 5'd4);
        step();
        in_valid = 1'b0;
        step();
        check("perf_acc_4", 64'(perf_acc), 64'd4);
        check("perf_stall_3", 64'(perf_stall), 64'd3);

        // stall counter saturation; flush must not clear counters
        out_ready = 1'b0;
        drive(ALU_SEL_ADD, 32'd5, 1'b0, 1'b0, 5'd5);
        step();
        in_valid = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        check("perf_stall_sat", 64'(perf_stall), 64'hFFFF);
        check("perf_acc_5", 64'(perf_acc), 64'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("perf_stall_flush", 64'(perf_stall), 64'hFFFF);
        check("perf_acc_flush", 64'(perf_acc), 64'd5);
`endif

        // final drain: nothing may remain outstanding
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        step();
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
